// File: rtl/barcode_scan_ctrl.sv
// -----------------------------------------------------------------------------
// barcode_scan_ctrl
//
// Session controller for the PS/2 barcode path. A one-cycle start arms the
// PS/2 decoder (scan_en) and opens a session. The controller then consumes
// scan-code set 2 bytes:
//   - digit make codes are packed into 13 BCD digits (first digit ends up in
//     the top nibble) while a running EAN-13 weighted sum is kept mod 10,
//   - each break prefix (F0h) discards the byte that follows it,
//   - extended prefixes (E0h) are dropped, so E0h 5Ah acts as a plain Enter,
//   - Enter closes the session and the check digit is verified.
// The session ends with a single code_valid or code_err pulse. err_code
// classifies the failure and is held until the next start.
//
// Ports
//   clk           in   1   system clock
//   rst_n         in   1   synchronous reset, ACTIVE-HIGH (1 = reset)
//   start         in   1   one-cycle session request, ignored while busy
//   ps2_done      in   1   one-cycle strobe, ps2_out_data holds a new byte
//   ps2_out_data  in   8   received PS/2 byte
//   scan_en       out  1   enable to the PS/2 decoder (same as busy)
//   busy          out  1   session active
//   code_bcd      out  52  13 BCD digits, first received in [51:48]
//   code_valid    out  1   one-cycle pulse, code_bcd holds a checked code
//   code_err      out  1   one-cycle pulse, the session failed
//   err_code      out  3   0 none, 1 illegal key, 2 length, 3 checksum,
//                          4 timeout
// -----------------------------------------------------------------------------
module barcode_scan_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned DIGITS         = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ps2_done,
  input  logic [7:0]            ps2_out_data,
  output logic                  scan_en,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   code_bcd,
  output logic                  code_valid,
  output logic                  code_err,
  output logic [2:0]            err_code
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL  = CW'(DIGITS);
  localparam logic [CW-1:0] COUNT_CHECK = CW'(DIGITS - 1);

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_BREAK   = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ILLEGAL  = 3'd1,
    ERR_LENGTH   = 3'd2,
    ERR_CHECKSUM = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } err_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e          r_state;
  logic [BW-1:0]   r_code_bcd;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_acc;
  logic [TW-1:0]   r_timer;
  logic            r_code_valid;
  logic            r_code_err;
  err_e            r_err_code;

  // Next-state values
  state_e          w_state_nxt;
  logic [BW-1:0]   w_bcd_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [3:0]      w_acc_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic            w_valid_nxt;
  logic            w_err_nxt;
  err_e            w_err_code_nxt;

  // Error request raised by the state logic, applied in one place below
  logic            w_fail;
  err_e            w_fail_code;

  // ---------------------------------------------------------------------------
  // Scan-code set 2 digit decoder
  // ---------------------------------------------------------------------------
  logic            w_is_digit;
  logic [3:0]      w_digit;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    unique case (ps2_out_data)
      8'h45:   w_digit = 4'd0;
      8'h16:   w_digit = 4'd1;
      8'h1E:   w_digit = 4'd2;
      8'h26:   w_digit = 4'd3;
      8'h25:   w_digit = 4'd4;
      8'h2E:   w_digit = 4'd5;
      8'h36:   w_digit = 4'd6;
      8'h3D:   w_digit = 4'd7;
      8'h3E:   w_digit = 4'd8;
      8'h46:   w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EAN-13 running sum. Positions 1,3,..,11 weigh 1 and positions 2,..,12
  // weigh 3; r_count is the 0-based index, so an odd count means weight 3.
  // The sum never exceeds 9 + 27 = 36, so three compares reduce it mod 10.
  // ---------------------------------------------------------------------------
  logic [5:0]      w_term;
  logic [5:0]      w_sum;
  logic [5:0]      w_sum_mod;
  logic [3:0]      w_check_digit;

  always_comb begin
    w_term = r_count[0] ? ({2'b00, w_digit} + {1'b0, w_digit, 1'b0})
                        : {2'b00, w_digit};
    w_sum  = {2'b00, r_acc} + w_term;
    if (w_sum >= 6'd30)      w_sum_mod = w_sum - 6'd30;
    else if (w_sum >= 6'd20) w_sum_mod = w_sum - 6'd20;
    else if (w_sum >= 6'd10) w_sum_mod = w_sum - 6'd10;
    else                     w_sum_mod = w_sum;
  end

  // Check digit implied by the first twelve digits: (10 - acc) mod 10
  assign w_check_digit = (r_acc == 4'd0) ? 4'd0 : (4'd10 - r_acc);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_bcd_nxt      = r_code_bcd;
    w_count_nxt    = r_count;
    w_acc_nxt      = r_acc;
    w_timer_nxt    = r_timer;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = r_err_code;
    w_fail         = 1'b0;
    w_fail_code    = ERR_NONE;

    unique case (r_state)
      ST_IDLE: begin
        // A byte arriving together with start belongs to no session
        if (start) begin
          w_state_nxt    = ST_COLLECT;
          w_bcd_nxt      = '0;
          w_count_nxt    = '0;
          w_acc_nxt      = 4'd0;
          w_timer_nxt    = '0;
          w_err_code_nxt = ERR_NONE;
        end
      end

      ST_COLLECT: begin
        if (ps2_done) begin
          w_timer_nxt = '0;
          if (w_is_digit) begin
            if (r_count == COUNT_FULL) begin
              w_fail      = 1'b1;
              w_fail_code = ERR_LENGTH;
            end else begin
              w_bcd_nxt   = {r_code_bcd[BW-5:0], w_digit};
              w_count_nxt = r_count + 1'b1;
              // The check digit itself is stored but not summed
              if (r_count != COUNT_CHECK) begin
                w_acc_nxt = w_sum_mod[3:0];
              end
            end
          end else if (ps2_out_data == KEY_BREAK) begin
            w_state_nxt = ST_BREAK;
          end else if (ps2_out_data == KEY_EXT) begin
            w_state_nxt = ST_COLLECT;
          end else if (ps2_out_data == KEY_ENTER) begin
            if (r_count == COUNT_FULL) begin
              w_state_nxt = ST_CHECK;
            end else begin
              w_fail      = 1'b1;
              w_fail_code = ERR_LENGTH;
            end
          end else begin
            w_fail      = 1'b1;
            w_fail_code = ERR_ILLEGAL;
          end
        end else if (r_timer == TIMER_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      ST_BREAK: begin
        // The released key's code is discarded whatever it is
        if (ps2_done) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_COLLECT;
        end else if (r_timer == TIMER_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (w_check_digit == r_code_bcd[3:0]) begin
          w_valid_nxt = 1'b1;
        end else begin
          w_fail      = 1'b1;
          w_fail_code = ERR_CHECKSUM;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Any failure closes the session; code_bcd keeps its partial contents
    if (w_fail) begin
      w_state_nxt    = ST_IDLE;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = w_fail_code;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst_n) begin
      r_state      <= ST_IDLE;
      r_code_bcd   <= '0;
      r_count      <= '0;
      r_acc        <= 4'd0;
      r_timer      <= '0;
      r_code_valid <= 1'b0;
      r_code_err   <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_code_bcd   <= w_bcd_nxt;
      r_count      <= w_count_nxt;
      r_acc        <= w_acc_nxt;
      r_timer      <= w_timer_nxt;
      r_code_valid <= w_valid_nxt;
      r_code_err   <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign busy       = (r_state != ST_IDLE);
  assign scan_en    = busy;
  assign code_bcd   = r_code_bcd;
  assign code_valid = r_code_valid;
  assign code_err   = r_code_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_barcode_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_barcode_scan_ctrl
//
// Self-checking bench for barcode_scan_ctrl (TIMEOUT_CYCLES = 100).
// A session model keeps the received digits in an array and evaluates the
// EAN-13 rule over the whole digit list when Enter is seen. A compare process
// checks every DUT output against the model on each falling edge. The
// directed scenarios also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_barcode_scan_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ps2_done;
  logic [7:0]  ps2_out_data;
  logic        scan_en;
  logic        busy;
  logic [51:0] code_bcd;
  logic        code_valid;
  logic        code_err;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  barcode_scan_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .DIGITS         (13)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ps2_done     (ps2_done),
    .ps2_out_data (ps2_out_data),
    .scan_en      (scan_en),
    .busy         (busy),
    .code_bcd     (code_bcd),
    .code_valid   (code_valid),
    .code_err     (code_err),
    .err_code     (err_code)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Session model
  // ---------------------------------------------------------------------------
  logic [7:0] make_code [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  bit m_active   = 1'b0;
  bit m_brk      = 1'b0;
  bit m_check    = 1'b0;
  bit m_valid    = 1'b0;
  bit m_err      = 1'b0;
  int m_err_code = 0;
  int m_idle     = 0;
  int m_n        = 0;
  int m_digits [14];

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (make_code[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [51:0] model_bcd();
    logic [51:0] r = '0;
    for (int i = 0; i < m_n; i++) r = {r[47:0], 4'(m_digits[i])};
    return r;
  endfunction

  function automatic bit model_checksum_ok();
    int s = 0;
    for (int i = 0; i < 12; i++) s += m_digits[i] * (((i % 2) == 0) ? 1 : 3);
    return ((10 - (s % 10)) % 10) == m_digits[12];
  endfunction

  task automatic model_fail(input int code);
    m_err      = 1'b1;
    m_err_code = code;
    m_active   = 1'b0;
    m_brk      = 1'b0;
  endtask

  initial forever begin : model_blk
    int d;
    @(posedge clk);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst_n === 1'b1) begin
      m_active = 0; m_brk = 0; m_check = 0; m_err_code = 0; m_idle = 0; m_n = 0;
    end else if (m_check) begin
      m_check  = 1'b0;
      m_active = 1'b0;
      if (model_checksum_ok()) m_valid = 1'b1;
      else model_fail(3);
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_brk = 0; m_err_code = 0; m_idle = 0; m_n = 0;
      end
    end else if (ps2_done) begin
      m_idle = 0;
      if (m_brk) begin
        m_brk = 1'b0;
      end else begin
        d = digit_of(ps2_out_data);
        if (d >= 0) begin
          if (m_n == 13) model_fail(2);
          else begin
            m_digits[m_n] = d;
            m_n++;
          end
        end else if (ps2_out_data == 8'hF0) m_brk = 1'b1;
        else if (ps2_out_data == 8'hE0) m_brk = 1'b0;
        else if (ps2_out_data == 8'h5A) begin
          if (m_n == 13) m_check = 1'b1;
          else model_fail(2);
        end else model_fail(1);
      end
    end else if (m_idle == TO - 1) begin
      model_fail(4);
    end else begin
      m_idle++;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle compare, on the falling edge
  // ---------------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("busy",       64'(busy),       64'(m_active));
      check("scan_en",    64'(scan_en),    64'(m_active));
      check("code_valid", 64'(code_valid), 64'(m_valid));
      check("code_err",   64'(code_err),   64'(m_err));
      check("err_code",   64'(err_code),   64'(m_err_code));
      check("code_bcd",   64'(code_bcd),   64'(model_bcd()));
      check("pulse_excl", 64'(code_valid & code_err), 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  int t1 [13] = '{4, 0, 0, 6, 3, 8, 1, 3, 3, 3, 9, 3, 1};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_done     = 1'b1;
    ps2_out_data = b;
    @(negedge clk);
    ps2_done     = 1'b0;
    ps2_out_data = 8'h00;
  endtask

  // Make code, gap, break prefix, released code, gap
  task automatic key(input int d);
    send(make_code[d]);
    cyc(1);
    send(8'hF0);
    send(make_code[d]);
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; ps2_done = 1'b0; ps2_out_data = 8'h00;
    cyc(3);
    rst_n  = 1'b0;
    cmp_en = 1'b1;
    check("reset_busy",     64'(busy),     64'd0);
    check("reset_bcd",      64'(code_bcd), 64'd0);
    check("reset_err_code", 64'(err_code), 64'd0);

    // 1. Valid code with break sequences
    pulse_start();
    for (int i = 0; i < 13; i++) key(t1[i]);
    send(8'h5A);
    check("t1_valid_early", 64'(code_valid), 64'd0);
    check("t1_busy_check",  64'(busy),       64'd1);
    cyc(1);
    check("t1_valid",       64'(code_valid), 64'd1);
    check("t1_model_valid", 64'(m_valid),    64'd1);
    check("t1_bcd",         64'(code_bcd),   64'h4006381333931);
    check("t1_model_bcd",   64'(model_bcd()), 64'h4006381333931);
    check("t1_err_code",    64'(err_code),   64'd0);
    check("t1_busy",        64'(busy),       64'd0);
    cyc(1);
    check("t1_pulse_end",   64'(code_valid), 64'd0);

    // 2. Checksum failure, last digit 2
    pulse_start();
    for (int i = 0; i < 12; i++) key(t1[i]);
    key(2);
    send(8'h5A);
    check("t2_err_early", 64'(code_err), 64'd0);
    cyc(1);
    check("t2_err",      64'(code_err),  64'd1);
    check("t2_err_code", 64'(err_code),  64'd3);
    check("t2_bcd",      64'(code_bcd),  64'h4006381333932);
    cyc(3);
    check("t2_err_hold", 64'(err_code),  64'd3);

    // 3a. Twelve digits then Enter
    pulse_start();
    for (int i = 0; i < 12; i++) send(make_code[t1[i]]);
    send(8'h5A);
    check("t3a_err",      64'(code_err), 64'd1);
    check("t3a_err_code", 64'(err_code), 64'd2);
    check("t3a_busy",     64'(busy),     64'd0);
    cyc(2);

    // 3b. Fourteen digits
    pulse_start();
    for (int i = 0; i < 13; i++) send(make_code[t1[i]]);
    check("t3b_no_err_13", 64'(code_err), 64'd0);
    send(make_code[5]);
    check("t3b_err",      64'(code_err), 64'd1);
    check("t3b_err_code", 64'(err_code), 64'd2);
    check("t3b_bcd",      64'(code_bcd), 64'h4006381333931);
    cyc(2);

    // 4a. Illegal key after three digits
    pulse_start();
    for (int i = 0; i < 3; i++) send(make_code[t1[i]]);
    send(8'h1C);
    check("t4a_err",      64'(code_err), 64'd1);
    check("t4a_err_code", 64'(err_code), 64'd1);
    check("t4a_bcd",      64'(code_bcd), 64'h400);
    cyc(2);

    // 4b. Keypad Enter (E0 5A) after 13 digits
    pulse_start();
    for (int i = 0; i < 13; i++) send(make_code[t1[i]]);
    send(8'hE0);
    check("t4b_busy_e0", 64'(busy), 64'd1);
    send(8'h5A);
    cyc(1);
    check("t4b_valid", 64'(code_valid), 64'd1);
    check("t4b_bcd",   64'(code_bcd),   64'h4006381333931);
    cyc(2);

    // 5a. Timeout after one digit
    pulse_start();
    send(make_code[7]);
    for (int i = 0; i < 99; i++) begin
      cyc(1);
      check("t5a_no_err", 64'(code_err), 64'd0);
    end
    cyc(1);
    check("t5a_err",      64'(code_err), 64'd1);
    check("t5a_err_code", 64'(err_code), 64'd4);
    check("t5a_busy",     64'(busy),     64'd0);
    cyc(2);

    // 5b. Byte arriving in the expiry cycle wins
    pulse_start();
    send(make_code[7]);
    cyc(99);
    send(make_code[8]);
    check("t5b_no_err",  64'(code_err), 64'd0);
    check("t5b_busy",    64'(busy),     64'd1);
    check("t5b_bcd",     64'(code_bcd), 64'h78);
    send(8'h5A);
    check("t5b_len_err", 64'(err_code), 64'd2);
    cyc(2);

    // 6a. Reset mid-session
    pulse_start();
    key(4);
    key(0);
    rst_n = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    check("t6a_busy",     64'(busy),     64'd0);
    check("t6a_bcd",      64'(code_bcd), 64'd0);
    check("t6a_err_code", 64'(err_code), 64'd0);
    cyc(1);
    check("t6a_no_pulse", 64'(code_valid | code_err), 64'd0);

    // 6b. Start while busy is ignored
    pulse_start();
    key(t1[0]);
    key(t1[1]);
    pulse_start();
    for (int i = 2; i < 13; i++) key(t1[i]);
    send(8'h5A);
    cyc(1);
    check("t6b_valid", 64'(code_valid), 64'd1);
    check("t6b_bcd",   64'(code_bcd),   64'h4006381333931);
    cyc(2);

    // 6c. Bytes in IDLE, and with start, are ignored
    send(make_code[7]);
    send(make_code[9]);
    start = 1'b1; ps2_done = 1'b1; ps2_out_data = make_code[9];
    @(negedge clk);
    start = 1'b0; ps2_done = 1'b0; ps2_out_data = 8'h00;
    check("t6c_bcd_clear", 64'(code_bcd), 64'd0);
    for (int i = 0; i < 13; i++) send(make_code[t1[i]]);
    send(8'h5A);
    cyc(1);
    check("t6c_valid", 64'(code_valid), 64'd1);
    check("t6c_bcd",   64'(code_bcd),   64'h4006381333931);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
